// File: rtl/exe_stage_mt.sv
// Multithreaded execute stage: thread-tagged forwarding, load-use detection,
// single-cycle ALU, iterative multiplier and the EX/MEM pipeline register.
module exe_stage_mt #(
    parameter int DATA_W  = 32,
    parameter int TRD_W   = 3,
    parameter int RAW     = 5,
    parameter int MUL_BPC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid_ex,
    input  logic [2:0]        i_op_ex,
    input  logic [TRD_W-1:0]  i_trd_ex,
    input  logic [RAW-1:0]    i_rs_a_ex,
    input  logic [RAW-1:0]    i_rs_b_ex,
    input  logic [DATA_W-1:0] i_data_a_ex,
    input  logic [DATA_W-1:0] i_data_b_ex,
    input  logic [RAW-1:0]    i_rd_ex,
    input  logic              i_wr_en_ex,
    input  logic              i_ld_ex,
    input  logic              i_flush_ex,
    input  logic              i_stall_in,
    input  logic [TRD_W-1:0]  i_trd_wb,
    input  logic [RAW-1:0]    i_rd_wb,
    input  logic              i_wr_en_wb,
    input  logic [DATA_W-1:0] i_data_wb,
    output logic              o_valid_mem,
    output logic              o_wr_en_mem,
    output logic              o_ld_mem,
    output logic              o_ovf_mem,
    output logic [TRD_W-1:0]  o_trd_mem,
    output logic [RAW-1:0]    o_rd_mem,
    output logic [DATA_W-1:0] o_data_mem,
    output logic              o_stall_ex,
    output logic              o_mul_busy
);

    localparam int N     = DATA_W / MUL_BPC;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;

    logic                r_valid_mem;
    logic                r_wr_en_mem;
    logic                r_ld_mem;
    logic                r_ovf_mem;
    logic [TRD_W-1:0]    r_trd_mem;
    logic [RAW-1:0]      r_rd_mem;
    logic [DATA_W-1:0]   r_data_mem;

    logic                w_mem_wr;
    logic                w_mem_alu;
    logic                w_mem_ld;
    logic                w_wb_wr;
    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_op_b;
    logic                w_hazard;
    logic                w_is_mul;
    logic                w_stall_ex;
    logic                w_mul_start;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_res;
    logic                w_ovf;
    logic [DATA_W-1:0]   w_pp;
    logic [DATA_W-1:0]   w_pp0;

    // MEM forwards ALU results only; a load in MEM has no data yet.
    assign w_mem_wr  = r_valid_mem & r_wr_en_mem & (r_trd_mem == i_trd_ex) & (r_rd_mem != '0);
    assign w_mem_alu = w_mem_wr & ~r_ld_mem;
    assign w_mem_ld  = w_mem_wr & r_ld_mem;
    assign w_wb_wr   = i_wr_en_wb & (i_trd_wb == i_trd_ex) & (i_rd_wb != '0);

    assign w_op_a = (w_mem_alu & (r_rd_mem == i_rs_a_ex)) ? r_data_mem :
                    (w_wb_wr   & (i_rd_wb  == i_rs_a_ex)) ? i_data_wb  : i_data_a_ex;
    assign w_op_b = (w_mem_alu & (r_rd_mem == i_rs_b_ex)) ? r_data_mem :
                    (w_wb_wr   & (i_rd_wb  == i_rs_b_ex)) ? i_data_wb  : i_data_b_ex;

    assign w_hazard = i_valid_ex & w_mem_ld & (r_state == ST_IDLE) &
                      ((r_rd_mem == i_rs_a_ex) | (r_rd_mem == i_rs_b_ex));
    assign w_is_mul    = i_valid_ex & (i_op_ex == 3'd6);
    assign w_stall_ex  = w_hazard | (w_is_mul & (r_state != ST_DONE));
    assign w_mul_start = (r_state == ST_IDLE) & w_is_mul & ~w_hazard & ~i_flush_ex;

    assign w_sum  = w_op_a + w_op_b;
    assign w_diff = w_op_a - w_op_b;
    assign w_pp   = r_mcand * DATA_W'(r_mplier[MUL_BPC-1:0]);
    assign w_pp0  = w_op_a * DATA_W'(w_op_b[MUL_BPC-1:0]);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (i_op_ex)
            3'd0: begin
                w_res = w_sum;
                w_ovf = (w_op_a[DATA_W-1] == w_op_b[DATA_W-1]) & (w_sum[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            3'd1: begin
                w_res = w_diff;
                w_ovf = (w_op_a[DATA_W-1] != w_op_b[DATA_W-1]) & (w_diff[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            3'd2: w_res = w_op_a & w_op_b;
            3'd3: w_res = w_op_a | w_op_b;
            3'd4: w_res = w_op_a ^ w_op_b;
            3'd5: w_res = {{(DATA_W-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            3'd6: w_res = r_acc;
            default: w_res = w_op_b;
        endcase
    end

    // The first multiplier chunk is retired at capture, so r_cnt holds the
    // chunks still outstanding and RUN lasts N-1 cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_flush_ex) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mul_start) begin
                        r_acc    <= w_pp0;
                        r_mcand  <= w_op_a << MUL_BPC;
                        r_mplier <= w_op_b >> MUL_BPC;
                        r_cnt    <= CNT_W'(N - 1);
                        r_state  <= (N == 1) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << MUL_BPC;
                    r_mplier <= r_mplier >> MUL_BPC;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!i_stall_in) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid_mem <= 1'b0;
            r_wr_en_mem <= 1'b0;
            r_ld_mem    <= 1'b0;
            r_ovf_mem   <= 1'b0;
            r_trd_mem   <= '0;
            r_rd_mem    <= '0;
            r_data_mem  <= '0;
        end else if (i_flush_ex || (!i_stall_in && (w_stall_ex || !i_valid_ex))) begin
            r_valid_mem <= 1'b0;
            r_wr_en_mem <= 1'b0;
            r_ld_mem    <= 1'b0;
            r_ovf_mem   <= 1'b0;
            r_trd_mem   <= '0;
            r_rd_mem    <= '0;
            r_data_mem  <= '0;
        end else if (!i_stall_in) begin
            r_valid_mem <= 1'b1;
            r_wr_en_mem <= i_wr_en_ex;
            r_ld_mem    <= i_ld_ex;
            r_ovf_mem   <= w_ovf;
            r_trd_mem   <= i_trd_ex;
            r_rd_mem    <= i_rd_ex;
            r_data_mem  <= w_res;
        end
    end

    assign o_valid_mem = r_valid_mem;
    assign o_wr_en_mem = r_wr_en_mem;
    assign o_ld_mem    = r_ld_mem;
    assign o_ovf_mem   = r_ovf_mem;
    assign o_trd_mem   = r_trd_mem;
    assign o_rd_mem    = r_rd_mem;
    assign o_data_mem  = r_data_mem;
    assign o_stall_ex  = w_stall_ex;
    assign o_mul_busy  = (r_state != ST_IDLE);

endmodule
